tcp_tx_arb: RTL and testbench
=============================

Name: tcp_tx_arb

Overview:
- Packet-level arbiter that shares one ipv4 tx path among N independent TCP engine tx streams, for multi-connection builds with several TCP engines.
- Arrayed interfaces are not usable, so requester-side signals are flattened vectors; the output side drives the ipv4 tx port signals (d, v, sof, eof, err, payload_length, headers, done/busy).
- Grants whole packets, round-robin, holds the grant until the downstream done, and guards against stalled or runaway requesters.

Parameters:
- N, 4, number of requesting TCP engines (2..8).
- HDR_W, 400, width of the flattened per-packet header bundle (ipv4 + mac header).
- WAIT_TICKS, 100, cycles a granted requester has to present sof before the grant is revoked.
- MAX_BYTES, 1460, maximum payload bytes forwarded per packet before a forced abort.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester packet pending, level.
- gnt  output  N  one-hot grant.
- in_d  input  8*N  per-requester data, requester i on bits [8i+7:8i].
- in_v  input  N  per-requester data valid.
- in_sof  input  N  per-requester start of frame.
- in_eof  input  N  per-requester end of frame.
- in_err  input  N  per-requester error.
- in_len  input  16*N  per-requester payload_length, valid with sof.
- in_hdr  input  HDR_W*N  per-requester header bundle, valid with sof.
- done  output  N  one-cycle pulse to the granted requester when its packet completes.
- out_d  output  8  to ipv4 tx d.
- out_v  output  1  to ipv4 tx v.
- out_sof  output  1  to ipv4 tx sof.
- out_eof  output  1  to ipv4 tx eof.
- out_err  output  1  to ipv4 tx err.
- out_len  output  16  to ipv4 tx payload_length.
- out_hdr  output  HDR_W  to ipv4 tx header fields.
- out_busy  input  1  ipv4 tx busy.
- out_done  input  1  ipv4 tx done pulse.
- timeout  output  1  one-cycle pulse when a grant is revoked for no sof.

Behaviour:
- Reset (rst low, async): gnt, done, out_*, and timeout are 0; state IDLE; round-robin pointer last = N-1, so requester 0 wins first; counters 0.
- IDLE:
  - If |req and !out_busy, pick the first req[i] set, scanning from last+1 with modulo-N wrap.
  - Register gnt one-hot, set last = i, go to GRANT.
  - Grant is visible one cycle after req is sampled.
- GRANT:
  - Wait counter increments each cycle.
  - in_v[g] & in_sof[g] → latch in_len/in_hdr of g into out_len/out_hdr, go to XFER; the sof byte is forwarded.
  - req[g] falls before sof → clear gnt, return to IDLE, no timeout.
  - Counter reaches WAIT_TICKS → clear gnt, pulse timeout, return to IDLE; the pointer stays advanced so others are served.
- XFER:
  - out_d/v/sof/eof/err = granted requester's signals, registered, exactly 1-cycle latency.
  - v gaps are forwarded as out_v=0.
  - Non-granted in_* are ignored entirely.
  - Byte counter counts out_v bytes excluding header.
  - eof on a valid byte → go to DONE_WAIT.
  - Counter reaches MAX_BYTES without eof → force out_eof=1, out_err=1 on that byte, drop further input, go to DONE_WAIT.
- DONE_WAIT:
  - On out_done, pulse done[g] the next cycle, clear gnt the same cycle, go to IDLE.
  - A new grant is possible on the cycle after the return to IDLE (min 1 idle cycle between packets).
- out_hdr/out_len hold from sof latch until the next sof.
- Simultaneous: sof and timeout in the same cycle → sof wins. out_done arriving in XFER is ignored (only DONE_WAIT consumes it).
- Reset mid-packet: outputs drop to 0 immediately; the downstream sees a truncated frame and the requester must retry.

Optional Feature:
- Macro TCP_ARB_PRIO_EN.
- Defined: requester 0 has strict priority in IDLE (intended for the control/ACK-only engine); the round-robin pointer governs only requesters 1..N-1, and requester 0 never advances it.
- Not defined: pure round-robin over all N.

Test Plan:
- N=4, req=4'b0110 held, each sends a 10-byte packet, out_done 5 cycles after eof → grant order 1,2,1,2; out stream equals input delayed 1 cycle; done pulses once per packet.
- req[3]=1 with no sof for WAIT_TICKS=100 → gnt[3] drops at cycle 100, timeout pulses once, req[0] raised meanwhile is granted next.
- Requester 2 sends 1500 bytes with MAX_BYTES=1460 → byte 1460 carries out_eof=1 and out_err=1, remaining input is ignored, done[2] follows out_done.
- out_busy=1 with all req set → no gnt; out_busy falls → gnt[0] asserts one cycle later.
- rst low during XFER byte 5 → all outputs 0 asynchronously; after release, req[1] is granted first from pointer N-1 only if req[0]=0.
- TCP_ARB_PRIO_EN defined, req=4'b1011 continuously → order 0,0,0… while req[0] stays set; clearing req[0] yields 1,3,1,3.

Source files
------------

// File: rtl/tcp_tx_arb.sv
// Packet-level round-robin arbiter sharing one ipv4 tx path among N TCP engine tx streams.
// Optional build macro TCP_ARB_PRIO_EN: requester 0 gets strict priority outside the round-robin.
module tcp_tx_arb #(
  parameter int N          = 4,
  parameter int HDR_W      = 400,
  parameter int WAIT_TICKS = 100,
  parameter int MAX_BYTES  = 1460
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  input  logic [8*N-1:0]       in_d,
  input  logic [N-1:0]         in_v,
  input  logic [N-1:0]         in_sof,
  input  logic [N-1:0]         in_eof,
  input  logic [N-1:0]         in_err,
  input  logic [16*N-1:0]      in_len,
  input  logic [HDR_W*N-1:0]   in_hdr,
  output logic [N-1:0]         done,
  output logic [7:0]           out_d,
  output logic                 out_v,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_err,
  output logic [15:0]          out_len,
  output logic [HDR_W-1:0]     out_hdr,
  input  logic                 out_busy,
  input  logic                 out_done,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(WAIT_TICKS + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE_WAIT} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   pick_idx;
  logic            pick_v;
  logic [WW-1:0]   wait_cnt;
  logic [BW-1:0]   byte_cnt;

  logic [7:0]       d_a   [N];
  logic [15:0]      len_a [N];
  logic [HDR_W-1:0] hdr_a [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign d_a[i]   = in_d[8*i +: 8];
    assign len_a[i] = in_len[16*i +: 16];
    assign hdr_a[i] = in_hdr[HDR_W*i +: HDR_W];
  end

  logic       sel_req, sel_v, sel_sof, sel_eof, sel_err, fwd;
  logic [7:0] sel_d;

  assign sel_req = req[gidx];
  assign sel_v   = in_v[gidx];
  assign sel_sof = in_sof[gidx];
  assign sel_eof = in_eof[gidx];
  assign sel_err = in_err[gidx];
  assign sel_d   = d_a[gidx];

  // The sof byte is forwarded from GRANT, so the forwarding path covers it as well as XFER.
  assign fwd = (state == XFER) || ((state == GRANT) && sel_v && sel_sof);

  always_comb begin
    int unsigned  cand;
    logic [IW-1:0] ci;
    pick_v   = 1'b0;
    pick_idx = '0;
    cand     = 0;
    ci       = '0;
    for (int unsigned k = 1; k <= unsigned'(N); k++) begin
      cand = 32'(last) + k;
      if (cand >= unsigned'(N)) cand = cand - unsigned'(N);
      ci = IW'(cand);
`ifdef TCP_ARB_PRIO_EN
      if (!pick_v && (ci != '0) && req[ci]) begin
`else
      if (!pick_v && req[ci]) begin
`endif
        pick_v   = 1'b1;
        pick_idx = ci;
      end
    end
`ifdef TCP_ARB_PRIO_EN
    if (req[0]) begin
      pick_v   = 1'b1;
      pick_idx = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= LAST_INIT;
      gidx     <= '0;
      gnt      <= '0;
      done     <= '0;
      timeout  <= 1'b0;
      wait_cnt <= '0;
      byte_cnt <= '0;
      out_d    <= '0;
      out_v    <= 1'b0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      out_err  <= 1'b0;
      out_len  <= '0;
      out_hdr  <= '0;
    end else begin
      done    <= '0;
      timeout <= 1'b0;
      out_d   <= '0;
      out_v   <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      out_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_v && !out_busy) begin
            gnt      <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            gidx     <= pick_idx;
`ifdef TCP_ARB_PRIO_EN
            if (pick_idx != '0) last <= pick_idx;
`else
            last     <= pick_idx;
`endif
            wait_cnt <= '0;
            byte_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (sel_v && sel_sof) begin
            out_len <= len_a[gidx];
            out_hdr <= hdr_a[gidx];
            state   <= XFER;
          end else if (!sel_req) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (wait_cnt == WW'(WAIT_TICKS - 1)) begin
            gnt     <= '0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        XFER: ;
        DONE_WAIT: begin
          if (out_done) begin
            done  <= gnt;
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Later assignments here override the state chosen above for the sof byte.
      if (fwd) begin
        out_d   <= sel_d;
        out_v   <= sel_v;
        out_sof <= sel_sof;
        out_eof <= sel_eof;
        out_err <= sel_err;
        if (sel_v) begin
          byte_cnt <= byte_cnt + BW'(1);
          if (sel_eof) begin
            state <= DONE_WAIT;
          end else if (byte_cnt == BW'(MAX_BYTES - 1)) begin
            out_eof <= 1'b1;
            out_err <= 1'b1;
            state   <= DONE_WAIT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tcp_tx_arb.sv
// Self-checking bench for tcp_tx_arb: directed scenarios with randomized packet content,
// checked against a packet-level arbitration/forwarding model.
module tb_tcp_tx_arb;

  localparam int N  = 4;
  localparam int HW = 400;
  localparam int WT = 100;
  localparam int MB = 1460;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic [8*N-1:0]    in_d;
  logic [N-1:0]      in_v, in_sof, in_eof, in_err;
  logic [16*N-1:0]   in_len;
  logic [HW*N-1:0]   in_hdr;
  logic [N-1:0]      done;
  logic [7:0]        out_d;
  logic              out_v, out_sof, out_eof, out_err;
  logic [15:0]       out_len;
  logic [HW-1:0]     out_hdr;
  logic              out_busy, out_done, timeout;

  int checks = 0;
  int errors = 0;
  int m_last;

  always #5 clk = ~clk;

  tcp_tx_arb #(.N(N), .HDR_W(HW), .WAIT_TICKS(WT), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .in_d(in_d), .in_v(in_v), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
    .in_len(in_len), .in_hdr(in_hdr), .done(done),
    .out_d(out_d), .out_v(out_v), .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err),
    .out_len(out_len), .out_hdr(out_hdr), .out_busy(out_busy), .out_done(out_done),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester after the last winner, wrapping modulo N.
  function automatic int pick(input logic [N-1:0] r, input int lst);
`ifdef TCP_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (lst + k) % N;
`ifdef TCP_ARB_PRIO_EN
      if (c != 0 && r[c]) return c;
`else
      if (r[c]) return c;
`endif
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    if (i < 0) return '0;
    return N'(1) << i;
  endfunction

  task automatic clear_lanes();
    in_v = '0; in_sof = '0; in_eof = '0; in_err = '0; in_d = '0; out_done = 1'b0;
  endtask

  task automatic noise(input int r);
    for (int i = 0; i < N; i++) begin
      if (i != r) begin
        in_v[i]        = 1'($urandom);
        in_sof[i]      = 1'($urandom);
        in_eof[i]      = 1'($urandom);
        in_err[i]      = 1'($urandom);
        in_d[i*8 +: 8] = 8'($urandom);
        in_len[i*16 +: 16] = 16'($urandom);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_done"}, done, '0);
    chk({tag, "_out_v"}, out_v, 1'b0);
    chk({tag, "_out_d"}, out_d, '0);
    chk({tag, "_out_sof"}, out_sof, 1'b0);
    chk({tag, "_out_eof"}, out_eof, 1'b0);
    chk({tag, "_out_err"}, out_err, 1'b0);
    chk({tag, "_out_len"}, out_len, '0);
    chk({tag, "_out_hdr"}, out_hdr, '0);
    chk({tag, "_timeout"}, timeout, 1'b0);
  endtask

  task automatic wait_grant(output int w);
    w = pick(req, m_last);
    for (int i = 0; i < 8 && gnt === '0; i++) step();
    chk("gnt", gnt, oh(w));
`ifdef TCP_ARB_PRIO_EN
    if (w > 0) m_last = w;
`else
    if (w >= 0) m_last = w;
`endif
  endtask

  task automatic run_packet(input int nbytes, input int dly, input logic [N-1:0] next_req);
    int r, sent, fwd, pre;
    logic [15:0] len;
    logic [HW-1:0] hdr;
    bit started, cut, fin;
    logic dv, dsof, deof, derr, ev, esof, eeof, eerr;
    logic [7:0] dd, ed;
    wait_grant(r);
    if (r < 0) return;
    len = 16'($urandom);
    for (int b = 0; b < HW/8; b++) hdr[b*8 +: 8] = 8'($urandom);
    for (int i = 0; i < N; i++) in_hdr[i*HW +: HW] = ~hdr;
    in_len[r*16 +: 16] = len;
    in_hdr[r*HW +: HW] = hdr;
    pre = $urandom_range(0, 3);
    sent = 0; fwd = 0; started = 0; cut = 0; fin = 0;
    while (!fin) begin
      noise(r);
      out_done = cut ? 1'b0 : 1'($urandom_range(0, 7) == 0);
      if (pre > 0) begin
        pre--;
        dv = 1'b0;
      end else begin
        dv = (sent == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      end
      dd   = 8'($urandom);
      dsof = dv && (sent == 0);
      deof = dv && (sent == nbytes - 1);
      derr = dv && ($urandom_range(0, 15) == 0);
      in_v[r] = dv; in_d[r*8 +: 8] = dd; in_sof[r] = dsof; in_eof[r] = deof; in_err[r] = derr;
      if (dsof) started = 1;
      if (started && !cut) begin
        ev = dv; ed = dd; esof = dsof; eeof = deof; eerr = derr;
        if (dv) begin
          fwd++;
          if (deof) cut = 1;
          else if (fwd == MB) begin eeof = 1'b1; eerr = 1'b1; cut = 1; end
        end
      end else begin
        ev = 0; ed = '0; esof = 0; eeof = 0; eerr = 0;
      end
      if (dv) sent++;
      if (sent == nbytes) fin = 1;
      step();
      chk("out_v", out_v, ev);
      if (ev) chk("out_d", out_d, ed);
      chk("out_sof", out_sof, esof);
      chk("out_eof", out_eof, eeof);
      chk("out_err", out_err, eerr);
      chk("gnt_hold", gnt, oh(r));
      if (dsof) begin
        chk("out_len_sof", out_len, len);
        chk("out_hdr_sof", out_hdr, hdr);
        in_len[r*16 +: 16] = ~len;
        in_hdr[r*HW +: HW] = ~hdr;
      end
    end
    clear_lanes();
    for (int i = 0; i < dly; i++) begin
      step();
      chk("idle_out_v", out_v, 1'b0);
      chk("done_early", done, '0);
      chk("gnt_wait", gnt, oh(r));
    end
    out_done = 1'b1;
    step();
    out_done = 1'b0;
    chk("done_pulse", done, oh(r));
    chk("gnt_clear", gnt, '0);
    chk("out_len_hold", out_len, len);
    chk("out_hdr_hold", out_hdr, hdr);
    req = next_req;
    step();
    chk("done_once", done, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int w, cyc;
    rst = 1'b0; req = '0; out_busy = 1'b0; in_len = '0; in_hdr = '0;
    clear_lanes();
    step(); step(); step();
    chk_all_zero("reset");
    rst = 1'b1;
    m_last = N - 1;

    // Downstream busy blocks granting; release yields a grant one cycle later.
    out_busy = 1'b1;
    req = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_no_gnt", gnt, '0);
    end
    out_busy = 1'b0;
    w = pick(req, m_last);
    step();
    chk("busy_release_gnt", gnt, oh(w));
`ifdef TCP_ARB_PRIO_EN
    if (w > 0) m_last = w;
`else
    m_last = w;
`endif
    req = '0;
    step();
    chk("req_drop_gnt", gnt, '0);
    chk("req_drop_no_timeout", timeout, 1'b0);

    // Two requesters held; four 10-byte packets.
    req = 4'b0110;
    for (int p = 0; p < 4; p++) run_packet(10, 5, (p == 3) ? 4'b0000 : 4'b0110);

    // Grant revoked after WAIT_TICKS without sof; requester 0 raised meanwhile.
    req = 4'b1000;
    wait_grant(w);
    cyc = 1;
    while (cyc < WT + 20) begin
      noise(3);
      if (cyc == 50) req[0] = 1'b1;
      step();
      if (gnt === '0) break;
      chk("timeout_early", timeout, 1'b0);
      cyc++;
    end
    chk("grant_cycles", cyc, WT);
    chk("timeout_pulse", timeout, 1'b1);
    clear_lanes();
    wait_grant(w);
    chk("timeout_once", timeout, 1'b0);
    req = '0;
    step();
    chk("revoke_req_drop", gnt, '0);

    // Runaway packet truncated at MAX_BYTES.
    req = 4'b0100;
    run_packet(1500, 4, 4'b0000);

    // Reset in the middle of a packet.
    req = 4'b0010;
    wait_grant(w);
    for (int b = 0; b < 5; b++) begin
      logic [7:0] x;
      x = 8'($urandom);
      in_v[w] = 1'b1; in_sof[w] = (b == 0); in_d[w*8 +: 8] = x;
      step();
      chk("pre_reset_v", out_v, 1'b1);
      chk("pre_reset_d", out_d, x);
    end
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    m_last = N - 1;
    step(); step();
    chk_all_zero("reset_hold");
    clear_lanes();
    rst = 1'b1;
    run_packet(12, 3, 4'b0000);

    // Random requester sets and packet lengths, including single-byte packets.
    for (int p = 0; p < 8; p++) begin
      req = N'($urandom_range(1, 15));
      run_packet($urandom_range(1, 30), $urandom_range(1, 6), 4'b0000);
    end

    // Requester 0 held with others, then removed.
    req = 4'b1011;
    for (int p = 0; p < 3; p++) run_packet($urandom_range(1, 12), 2, (p == 2) ? 4'b1010 : 4'b1011);
    for (int p = 0; p < 4; p++) run_packet($urandom_range(1, 12), 2, (p == 3) ? 4'b0000 : 4'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
